// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock)
// with valid/ready handshakes and optional two's-complement input.
module bin2bcd_seq #(
   parameter int unsigned IN_W   = 9,
   parameter int unsigned DIGITS = 3,
   parameter int unsigned SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [IN_W-1:0]       in_bin,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  out_neg
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(IN_W + 1);
   localparam int unsigned CHK_W = IN_W + BCD_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   // True when DIGITS decimal digits can represent the largest input magnitude.
   function automatic bit range_ok();
      logic [CHK_W-1:0] pow10;
      logic [CHK_W-1:0] mag_max;
      pow10 = CHK_W'(1);
      for (int i = 0; i < int'(DIGITS); i++) begin
         pow10 = CHK_W'(pow10 * CHK_W'(10));
      end
      if (SIGNED != 0) begin
         mag_max = CHK_W'(1) << (IN_W - 1);
      end else begin
         mag_max = (CHK_W'(1) << IN_W) - CHK_W'(1);
      end
      return pow10 > mag_max;
   endfunction

   if (IN_W < 2) begin : g_width_chk
      $error("bin2bcd_seq: IN_W must be at least 2");
   end

   if (!range_ok()) begin : g_range_chk
      $error("bin2bcd_seq: DIGITS too small for the IN_W magnitude range");
   end

   logic [1:0]       state_q, state_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [IN_W-1:0]  mag_q, mag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic             valid_q, valid_d;
   logic             ready_q, ready_d;

   logic             in_neg_c;
   logic [IN_W-1:0]  in_mag_c;
   logic [BCD_W-1:0] adj_c;

   // Magnitude at IN_W bits: the most negative value maps onto itself as unsigned.
   assign in_neg_c = (SIGNED != 0) && in_bin[IN_W-1];
   assign in_mag_c = in_neg_c ? ((~in_bin) + IN_W'(1)) : in_bin;

   // Add 3 to every digit that is 5 or more before the next doubling.
   always_comb begin
      adj_c = bcd_q;
      for (int d = 0; d < int'(DIGITS); d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) begin
            adj_c[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      valid_d = valid_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               bcd_d   = '0;
               mag_d   = in_mag_c;
               neg_d   = in_neg_c;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            bcd_d = BCD_W'({adj_c, mag_q[IN_W-1]});
            mag_d = IN_W'({mag_q, 1'b0});
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(IN_W - 1)) begin
               state_d = S_DONE;
               valid_d = 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   assign ready_d = (state_d == S_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         bcd_q   <= '0;
         mag_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         mag_q   <= mag_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = valid_q;
   assign out_bcd   = bcd_q;
   assign out_neg   = neg_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: default, signed and wide instances,
// directed cases plus randomized traffic against a divide/modulo reference.
module tb_bin2bcd_seq;

   logic        clk;
   logic        rst_n;
   logic [2:0]  iv;
   logic [2:0]  ordy;
   logic [8:0]  bin0, bin1;
   logic [15:0] bin2;
   logic        ir0, ir1, ir2;
   logic        ov0, ov1, ov2;
   logic [11:0] bcd0, bcd1;
   logic [19:0] bcd2;
   logic        neg0, neg1, neg2;

   int n_checks = 0;
   int n_fail   = 0;

   bin2bcd_seq #(.IN_W(9), .DIGITS(3), .SIGNED(0)) u_def (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_bin(bin0), .in_ready(ir0),
      .out_valid(ov0), .out_ready(ordy[0]), .out_bcd(bcd0), .out_neg(neg0));

   bin2bcd_seq #(.IN_W(9), .DIGITS(3), .SIGNED(1)) u_sgn (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_bin(bin1), .in_ready(ir1),
      .out_valid(ov1), .out_ready(ordy[1]), .out_bcd(bcd1), .out_neg(neg1));

   bin2bcd_seq #(.IN_W(16), .DIGITS(5), .SIGNED(0)) u_wide (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_bin(bin2), .in_ready(ir2),
      .out_valid(ov2), .out_ready(ordy[2]), .out_bcd(bcd2), .out_neg(neg2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Decimal digits by repeated division, units in the low nibble.
   function automatic logic [19:0] ref_bcd(input int unsigned v);
      logic [19:0] r;
      int unsigned x;
      x = v;
      for (int d = 0; d < 5; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic get_ir(input int s);
      case (s)
         0:       return ir0;
         1:       return ir1;
         default: return ir2;
      endcase
   endfunction

   function automatic logic get_ov(input int s);
      case (s)
         0:       return ov0;
         1:       return ov1;
         default: return ov2;
      endcase
   endfunction

   function automatic logic get_neg(input int s);
      case (s)
         0:       return neg0;
         1:       return neg1;
         default: return neg2;
      endcase
   endfunction

   function automatic logic [19:0] get_bcd(input int s);
      case (s)
         0:       return {8'h00, bcd0};
         1:       return {8'h00, bcd1};
         default: return bcd2;
      endcase
   endfunction

   task automatic drive_in(input int s, input int unsigned v, input logic vld);
      case (s)
         0:       bin0 = 9'(v);
         1:       bin1 = 9'(v);
         default: bin2 = 16'(v);
      endcase
      iv[s] = vld;
   endtask

   // One full conversion on instance s, holding the result for 'stall' cycles.
   task automatic convert(input int s, input int unsigned v, input int stall, input bit chk_lat);
      int unsigned w, mag;
      bit          neg, acc;
      int          n;
      logic [19:0] eb;
      w   = (s == 2) ? 16 : 9;
      neg = (s == 1) && v[8];
      mag = neg ? (512 - v) : v;
      eb  = ref_bcd(mag);
      drive_in(s, v, 1'b1);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
         acc = get_ir(s);
         tick();
         n++;
      end
      check("accept", 32'(acc), 32'd1);
      drive_in(s, 0, 1'b0);
      n = 0;
      while (!get_ov(s) && n < 50) begin
         if (n == 2) check("busy_ready", 32'(get_ir(s)), 32'd0);
         tick();
         n++;
      end
      if (chk_lat) check("latency", 32'(n), 32'(w));
      check("valid", 32'(get_ov(s)), 32'd1);
      check("bcd", 32'(get_bcd(s)), 32'(eb));
      check("neg", 32'(get_neg(s)), 32'(neg));
      for (int i = 0; i < stall; i++) begin
         tick();
         check("hold_valid", 32'(get_ov(s)), 32'd1);
         check("hold_bcd", 32'(get_bcd(s)), 32'(eb));
      end
      ordy[s] = 1'b1;
      tick();
      ordy[s] = 1'b0;
      check("drop_valid", 32'(get_ov(s)), 32'd0);
      check("idle_ready", 32'(get_ir(s)), 32'd1);
   endtask

   int unsigned sb_q[$];
   int          got_n;

   initial begin
      int  n, seen;
      bit  acc;
      rst_n = 1'b0;
      iv    = '0;
      ordy  = '0;
      bin0  = '0;
      bin1  = '0;
      bin2  = '0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int s = 0; s < 3; s++) begin
         check("rst_ready", 32'(get_ir(s)), 32'd1);
         check("rst_valid", 32'(get_ov(s)), 32'd0);
         check("rst_bcd", 32'(get_bcd(s)), 32'd0);
      end

      // Unsigned defaults and backpressure
      convert(0, 0, 0, 1'b1);
      convert(0, 255, 0, 1'b1);
      convert(0, 511, 0, 1'b1);
      convert(0, 100, 6, 1'b1);

      // Signed instance
      convert(1, 9'h100, 0, 1'b1);
      convert(1, 9'h1FF, 0, 1'b1);
      convert(1, 9'h0FF, 0, 1'b1);
      convert(1, 0, 1, 1'b1);

      // Wide instance
      convert(2, 65535, 0, 1'b1);
      convert(2, 10000, 2, 1'b1);

      // Reset in the middle of a conversion
      drive_in(0, 511, 1'b1);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
         acc = ir0;
         tick();
         n++;
      end
      check("rst_accept", 32'(acc), 32'd1);
      drive_in(0, 0, 1'b0);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_valid", 32'(ov0), 32'd0);
      check("midrst_bcd", 32'(bcd0), 32'd0);
      check("midrst_neg", 32'(neg0), 32'd0);
      check("midrst_ready", 32'(ir0), 32'd1);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (ov0) seen++;
         tick();
      end
      check("midrst_no_valid", 32'(seen), 32'd0);
      convert(0, 37, 0, 1'b1);

      // Random signed and wide conversions
      for (int i = 0; i < 100; i++) begin
         convert(1, $urandom_range(0, 511), int'($urandom_range(0, 1)), 1'b1);
      end
      for (int i = 0; i < 40; i++) begin
         convert(2, $urandom_range(0, 65535), int'($urandom_range(0, 1)), 1'b1);
      end

      // Randomized traffic with independent input and output stalls
      got_n = 0;
      fork
         begin
            int unsigned v;
            int          gap, k;
            bit          a;
            for (int i = 0; i < 2000; i++) begin
               v   = $urandom_range(0, 511);
               gap = int'($urandom_range(0, 2));
               for (int g = 0; g < gap; g++) tick();
               bin0  = 9'(v);
               iv[0] = 1'b1;
               k = 0;
               a = 1'b0;
               while (!a && k < 100) begin
                  a = ir0;
                  tick();
                  k++;
               end
               if (a) sb_q.push_back(v);
               else check("rand_accept", 32'(a), 32'd1);
               iv[0] = 1'b0;
               bin0  = 9'($urandom_range(0, 511));
            end
         end
         begin
            int          cyc;
            logic        vs;
            logic [11:0] bs;
            logic        ns;
            int unsigned e;
            cyc = 0;
            while (got_n < 2000 && cyc < 80000) begin
               ordy[0] = ($urandom_range(0, 3) != 0);
               vs = ov0;
               bs = bcd0;
               ns = neg0;
               tick();
               cyc++;
               if (vs && ordy[0]) begin
                  got_n++;
                  if (sb_q.size() == 0) begin
                     check("rand_extra", 32'(got_n), 32'd0);
                  end else begin
                     e = sb_q.pop_front();
                     check("rand_bcd", 32'(bs), 32'(ref_bcd(e)));
                     check("rand_neg", 32'(ns), 32'd0);
                  end
               end
            end
            ordy[0] = 1'b0;
         end
      join
      check("rand_count", 32'(got_n), 32'd2000);
      check("rand_left", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
